// File: rtl/alu_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcodes, FSM state
// encoding and the opcode legality check.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int OPND_W = 5;
    localparam int OP_W   = 4;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_LAST = OP_MUL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_LAST);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Four-state sequencer: accept one register-to-register instruction, read both
// operands, drive the external ALU, then write the result back to the bank.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int OPND_W_P = OPND_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [OP_W-1:0]     instr_op,
    input  logic [ADDR_W_P-1:0] instr_rs_a,
    input  logic [ADDR_W_P-1:0] instr_rs_b,
    input  logic [ADDR_W_P-1:0] instr_rd,
    output logic [ADDR_W_P-1:0] rf_raddr_a,
    output logic [ADDR_W_P-1:0] rf_raddr_b,
    input  logic [DATA_W_P-1:0] rf_rdata_a,
    input  logic [DATA_W_P-1:0] rf_rdata_b,
    output logic                rf_we,
    output logic [ADDR_W_P-1:0] rf_waddr,
    output logic [DATA_W_P-1:0] rf_wdata,
    output logic [OPND_W_P-1:0] alu_a,
    output logic [OPND_W_P-1:0] alu_b,
    output logic [OP_W-1:0]     alu_op,
    input  logic [DATA_W_P-1:0] alu_resul,
    output logic                done,
    output logic                err,
    output logic                busy
);

    state_e                state_q, state_d;
    logic [OP_W-1:0]       op_q, op_d;
    logic [ADDR_W_P-1:0]   rs_a_q, rs_a_d;
    logic [ADDR_W_P-1:0]   rs_b_q, rs_b_d;
    logic [ADDR_W_P-1:0]   rd_q, rd_d;
    logic [DATA_W_P-1:0]   res_q, res_d;
    logic                  legal;

    // Only the operand slice of the read data feeds the ALU.
    logic unused_rdata;
    assign unused_rdata = ^{rf_rdata_a[DATA_W_P-1:OPND_W_P], rf_rdata_b[DATA_W_P-1:OPND_W_P]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            rs_a_q  <= '0;
            rs_b_q  <= '0;
            rd_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs_a_q  <= rs_a_d;
            rs_b_q  <= rs_b_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs_a_d  = rs_a_q;
        rs_b_d  = rs_b_q;
        rd_d    = rd_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    op_d    = instr_op;
                    rs_a_d  = instr_rs_a;
                    rs_b_d  = instr_rs_b;
                    rd_d    = instr_rd;
                    state_d = READ;
                end
            end
            READ: state_d = EXEC;
            EXEC: begin
                res_d   = alu_resul;
                state_d = WB;
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend on state_q and latched fields only, so a reset drops them at once.
    always_comb begin
        legal       = op_is_legal(op_q);
        instr_ready = (state_q == IDLE);
        busy        = (state_q != IDLE);
        rf_raddr_a  = (state_q == READ) ? rs_a_q : '0;
        rf_raddr_b  = (state_q == READ) ? rs_b_q : '0;
        alu_a       = (state_q == EXEC) ? rf_rdata_a[OPND_W_P-1:0] : '0;
        alu_b       = (state_q == EXEC) ? rf_rdata_b[OPND_W_P-1:0] : '0;
        alu_op      = (state_q == EXEC) ? op_q : '0;
        rf_we       = (state_q == WB) && legal;
        rf_waddr    = (state_q == WB) ? rd_q : '0;
        rf_wdata    = (state_q == WB) ? res_q : '0;
        done        = (state_q == WB);
        err         = (state_q == WB) && !legal;
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench: synchronous-read register bank, behavioural ALU and a
// reference model of architectural register state.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [4:0]  instr_rs_a, instr_rs_b, instr_rd;
    logic [4:0]  rf_raddr_a, rf_raddr_b;
    logic [31:0] rf_rdata_a, rf_rdata_b;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_resul;
    logic        done, err, busy;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int wr_count = 0;

    logic [31:0] bank     [32];
    logic [31:0] ref_bank [32];
    logic        tb_we = 1'b0;
    logic [4:0]  tb_waddr = '0;
    logic [31:0] tb_wdata = '0;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rs_a(instr_rs_a), .instr_rs_b(instr_rs_b), .instr_rd(instr_rd),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_resul(alu_resul),
        .done(done), .err(err), .busy(busy)
    );

    // Register bank: synchronous read, one write port for the DUT, one for bench setup.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rf_rdata_a <= bank[rf_raddr_a];
        rf_rdata_b <= bank[rf_raddr_b];
        if (rf_we) begin
            bank[rf_waddr] <= rf_wdata;
            wr_count <= wr_count + 1;
        end
        if (tb_we) bank[tb_waddr] <= tb_wdata;
    end

    // Behavioural ALU; illegal opcodes produce a recognisable garbage value.
    always_comb begin
        case (alu_op)
            4'd0:    alu_resul = {27'd0, alu_a} + {27'd0, alu_b};
            4'd1:    alu_resul = {27'd0, alu_a} - {27'd0, alu_b};
            4'd2:    alu_resul = {27'd0, alu_a} & {27'd0, alu_b};
            4'd3:    alu_resul = {27'd0, alu_a} * {27'd0, alu_b};
            default: alu_resul = 32'hBAD0_0000 | {27'd0, alu_a};
        endcase
    end

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            0:       return a + b;
            1:       return a - b;
            2:       return a & b;
            3:       return a * b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input int idx, input logic [31:0] val);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = idx[4:0]; tb_wdata = val;
        ref_bank[idx] = val;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic wait_ready();
        int budget = 20;
        @(negedge clk);
        while (!instr_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("ready_timeout", {63'd0, instr_ready}, 64'd1);
    endtask

    // One full instruction with cycle-by-cycle checks against the reference model.
    task automatic run_instr(input int op, input int ra, input int rb, input int rd);
        logic [31:0] ea, eb, eres;
        logic        legal;
        int          wc0;
        wait_ready();
        instr_valid = 1'b1; instr_op = op[3:0];
        instr_rs_a = ra[4:0]; instr_rs_b = rb[4:0]; instr_rd = rd[4:0];
        ea    = {27'd0, ref_bank[ra][4:0]};
        eb    = {27'd0, ref_bank[rb][4:0]};
        legal = (op <= 3);
        eres  = ref_alu(op, ea, eb);
        wc0   = wr_count;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr_op = 4'($urandom); instr_rs_a = 5'($urandom); instr_rs_b = 5'($urandom); instr_rd = 5'($urandom);
        check("read_busy",   {63'd0, busy}, 64'd1);
        check("read_ready",  {63'd0, instr_ready}, 64'd0);
        check("read_addr_a", {59'd0, rf_raddr_a}, ra);
        check("read_addr_b", {59'd0, rf_raddr_b}, rb);
        @(posedge clk); #1;
        check("exec_alu_a",  {59'd0, alu_a}, ea);
        check("exec_alu_b",  {59'd0, alu_b}, eb);
        check("exec_alu_op", {60'd0, alu_op}, op);
        check("exec_we",     {63'd0, rf_we}, 64'd0);
        @(posedge clk); #1;
        check("wb_done", {63'd0, done}, 64'd1);
        check("wb_err",  {63'd0, err}, {63'd0, !legal});
        check("wb_we",   {63'd0, rf_we}, {63'd0, legal});
        if (legal) begin
            check("wb_waddr", {59'd0, rf_waddr}, rd);
            check("wb_wdata", {32'd0, rf_wdata}, {32'd0, eres});
            ref_bank[rd] = eres;
        end
        @(posedge clk); #1;
        check("idle_done",  {63'd0, done}, 64'd0);
        check("idle_ready", {63'd0, instr_ready}, 64'd1);
        check("bank_rd",    {32'd0, bank[rd]}, {32'd0, ref_bank[rd]});
        check("write_count", wr_count - wc0, legal ? 1 : 0);
        $display("instr op=%0d rs_a=%0d rs_b=%0d rd=%0d a=%0d b=%0d result=%08h legal=%0d",
                 op, ra, rb, rd, ea, eb, eres, legal);
    endtask

    initial begin
        int acc_cyc [3];
        int ops [3], ras [3], rbs [3], rds [3];
        int wc0;
        rst = 1'b1; instr_valid = 1'b0;
        instr_op = '0; instr_rs_a = '0; instr_rs_b = '0; instr_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {63'd0, instr_ready}, 64'd1);
        check("rst_busy",  {63'd0, busy}, 64'd0);
        check("rst_we",    {63'd0, rf_we}, 64'd0);
        check("rst_done_err", {62'd0, done, err}, 64'd0);
        check("rst_outs", {rf_raddr_a, rf_raddr_b, rf_waddr, alu_a, alu_b, alu_op} , 64'd0);
        check("rst_wdata", {32'd0, rf_wdata}, 64'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 32; i++) set_reg(i, $urandom);

        // Directed cases
        set_reg(1, 32'd7); set_reg(2, 32'd3);
        run_instr(0, 1, 2, 4);
        check("add_result", {32'd0, bank[4]}, 64'd10);
        set_reg(5, 32'd2); set_reg(6, 32'd9);
        run_instr(1, 5, 6, 7);
        check("sub_result", {32'd0, bank[7]}, 64'hFFFF_FFF9);
        set_reg(5, 32'd31); set_reg(6, 32'd31);
        run_instr(3, 5, 6, 7);
        check("mul_result", {32'd0, bank[7]}, 64'd961);
        run_instr(7, 1, 2, 4);
        check("illegal_keep", {32'd0, bank[4]}, 64'd10);
        set_reg(8, 32'h0000_0125); set_reg(9, 32'd3);
        run_instr(2, 8, 9, 10);
        check("and_trunc", {32'd0, bank[10]}, 64'd1);
        run_instr(0, 0, 0, 0);

        // Back-to-back with valid held high; third depends on first's rd.
        set_reg(1, 32'd7); set_reg(2, 32'd3); set_reg(3, 32'd20); set_reg(4, 32'd6);
        ops = '{0, 1, 0}; ras = '{1, 3, 11}; rbs = '{2, 4, 1}; rds = '{11, 12, 13};
        wait_ready();
        for (int k = 0; k < 3; k++) begin
            int budget = 20;
            instr_valid = 1'b1; instr_op = ops[k][3:0];
            instr_rs_a = ras[k][4:0]; instr_rs_b = rbs[k][4:0]; instr_rd = rds[k][4:0];
            while (!instr_ready && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            check("b2b_timeout", {63'd0, instr_ready}, 64'd1);
            acc_cyc[k] = cyc;
            ref_bank[rds[k]] = ref_alu(ops[k], {27'd0, ref_bank[ras[k]][4:0]}, {27'd0, ref_bank[rbs[k]][4:0]});
            @(negedge clk);
        end
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 64'd4);
        check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 64'd4);
        for (int k = 0; k < 3; k++)
            check("b2b_bank", {32'd0, bank[rds[k]]}, {32'd0, ref_bank[rds[k]]});
        check("b2b_dep", {32'd0, bank[13]}, 64'd17);
        $display("instr b2b accepts at cycles %0d %0d %0d", acc_cyc[0], acc_cyc[1], acc_cyc[2]);

        // Reset during EXEC: no write may reach the bank.
        set_reg(20, 32'h1234_5678);
        wait_ready();
        instr_valid = 1'b1; instr_op = 4'd0; instr_rs_a = 5'd1; instr_rs_b = 5'd2; instr_rd = 5'd20;
        wc0 = wr_count;
        @(posedge clk); #1; instr_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_exec", {60'd0, alu_op}, 64'd0);
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1; #1;
        check("arst_busy",  {63'd0, busy}, 64'd0);
        check("arst_ready", {63'd0, instr_ready}, 64'd1);
        check("arst_we",    {63'd0, rf_we}, 64'd0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("arst_no_write", wr_count - wc0, 64'd0);
        check("arst_bank", {32'd0, bank[20]}, 64'h1234_5678);
        $display("instr reset-in-exec rd=20 bank=%08h", bank[20]);

        // Randomized instructions against the reference model.
        for (int i = 0; i < 40; i++)
            run_instr($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
        for (int i = 0; i < 32; i++)
            check("final_bank", {32'd0, bank[i]}, {32'd0, ref_bank[i]});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
